// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, instruction-memory addressing and the IF/ID pipeline register.
// Handles hazard stalls and taken-branch redirects (one bubble per redirect), and counts delivered instructions.
module instruction_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_pc,
    input  logic [63:0] br_offset,
    output logic [31:0] ID_instruction,
    output logic [63:0] IFID_pc,
    output logic        IFID_valid,
    output logic [63:0] pc,
    output logic [31:0] instr_count
);

    logic [63:0] pc_plus4;
    logic [63:0] br_target;
    logic [31:0] count_inc;
    logic        advance;

    logic [63:0] pc_seq;
    logic [63:0] pc_next;
    logic [63:0] ifid_pc_seq;
    logic [63:0] ifid_pc_next;
    logic [31:0] instr_seq;
    logic [31:0] instr_next;
    logic [31:0] count_next;
    logic        valid_seq;
    logic        valid_next;

    // Both adders wrap modulo 2^64; offset bits shifted past bit 63 are dropped.
    assign pc_plus4  = pc + 64'd4;
    assign br_target = br_pc + (br_offset << 2);
    assign count_inc = instr_count + 32'd1;
    assign advance   = ~stall & ~br_taken;

    assign imem_addr = pc;

    // Two mux levels per bit: the inner level selects hold vs. advance,
    // the outer level lets a redirect override a simultaneous stall.
    for (genvar i = 0; i < 64; i++) begin : g_pc_mux
        assign pc_seq[i]       = stall    ? pc[i]        : pc_plus4[i];
        assign pc_next[i]      = br_taken ? br_target[i] : pc_seq[i];
        assign ifid_pc_seq[i]  = stall    ? IFID_pc[i]   : pc[i];
        assign ifid_pc_next[i] = br_taken ? 1'b0         : ifid_pc_seq[i];
    end

    for (genvar i = 0; i < 32; i++) begin : g_ifid_mux
        assign instr_seq[i]  = stall    ? ID_instruction[i] : imem_data[i];
        assign instr_next[i] = br_taken ? NOP_INSTR[i]      : instr_seq[i];
        assign count_next[i] = advance  ? count_inc[i]      : instr_count[i];
    end

    assign valid_seq  = stall    ? IFID_valid : 1'b1;
    assign valid_next = br_taken ? 1'b0       : valid_seq;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            ID_instruction <= NOP_INSTR;
            IFID_pc        <= 64'h0;
            IFID_valid     <= 1'b0;
            instr_count    <= 32'h0;
        end else begin
            pc             <= pc_next;
            ID_instruction <= instr_next;
            IFID_pc        <= ifid_pc_next;
            IFID_valid     <= valid_next;
            instr_count    <= count_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage; imem returns 32'h91000000 | addr.
module tb_instruction_fetch_stage;

    localparam logic [31:0] TAG = 32'h91000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_pc;
    logic [63:0] br_offset;
    logic [31:0] ID_instruction;
    logic [63:0] IFID_pc;
    logic        IFID_valid;
    logic [63:0] pc;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_data = TAG | imem_addr[31:0];

    instruction_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .br_taken       (br_taken),
        .br_pc          (br_pc),
        .br_offset      (br_offset),
        .ID_instruction (ID_instruction),
        .IFID_pc        (IFID_pc),
        .IFID_valid     (IFID_valid),
        .pc             (pc),
        .instr_count    (instr_count)
    );

    // Inputs change on negedge, outputs are sampled on the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_pc = '0; br_offset = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 64'h0); end
        checks++; if (ID_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", ID_instruction, 32'h0); end
        checks++; if (IFID_pc !== 64'h0) begin errors++; $display("FAIL reset_ifid_pc: got %h expected %h", IFID_pc, 64'h0); end
        checks++; if (IFID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", IFID_valid); end
        checks++; if (instr_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    endtask

    task automatic test_sequential();
        logic [63:0] exp_pc;
        logic [63:0] exp_ifid;
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_pc   = 64'(4 * i);
            exp_ifid = 64'(4 * (i - 1));
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, exp_pc); end
            checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL seq_imem_addr[%0d]: got %h expected %h", i, imem_addr, exp_pc); end
            checks++; if (IFID_pc !== exp_ifid) begin errors++; $display("FAIL seq_ifid_pc[%0d]: got %h expected %h", i, IFID_pc, exp_ifid); end
            checks++; if (ID_instruction !== (TAG | exp_ifid[31:0])) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, ID_instruction, TAG | exp_ifid[31:0]); end
            checks++; if (IFID_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, IFID_valid); end
            checks++; if (instr_count !== 32'(i)) begin errors++; $display("FAIL seq_count[%0d]: got %0d expected %0d", i, instr_count, i); end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== 64'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 8", i, pc); end
            checks++; if (IFID_pc !== 64'h4) begin errors++; $display("FAIL stall_ifid_pc[%0d]: got %h expected 4", i, IFID_pc); end
            checks++; if (ID_instruction !== 32'h91000004) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected 91000004", i, ID_instruction); end
            checks++; if (instr_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d expected 2", i, instr_count); end
        end
        stall = 1'b0;
        step();
        checks++; if (pc !== 64'hC) begin errors++; $display("FAIL unstall_pc: got %h expected c", pc); end
        checks++; if (IFID_pc !== 64'h8) begin errors++; $display("FAIL unstall_ifid_pc: got %h expected 8", IFID_pc); end
        checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL unstall_count: got %0d expected 3", instr_count); end
    endtask

    task automatic test_redirect();
        apply_reset();
        step();
        br_taken = 1'b1; br_pc = 64'h4; br_offset = 64'h2;
        step();
        br_taken = 1'b0;
        checks++; if (pc !== 64'hC) begin errors++; $display("FAIL br_pc: got %h expected c", pc); end
        checks++; if (IFID_valid !== 1'b0) begin errors++; $display("FAIL br_bubble_valid: got %b expected 0", IFID_valid); end
        checks++; if (ID_instruction !== 32'h0) begin errors++; $display("FAIL br_bubble_instr: got %h expected 0", ID_instruction); end
        checks++; if (IFID_pc !== 64'h0) begin errors++; $display("FAIL br_bubble_ifid_pc: got %h expected 0", IFID_pc); end
        checks++; if (instr_count !== 32'd1) begin errors++; $display("FAIL br_count: got %0d expected 1", instr_count); end
        step();
        checks++; if (IFID_pc !== 64'hC) begin errors++; $display("FAIL br_target_ifid_pc: got %h expected c", IFID_pc); end
        checks++; if (IFID_valid !== 1'b1) begin errors++; $display("FAIL br_target_valid: got %b expected 1", IFID_valid); end
        checks++; if (ID_instruction !== 32'h9100000C) begin errors++; $display("FAIL br_target_instr: got %h expected 9100000c", ID_instruction); end
        checks++; if (pc !== 64'h10) begin errors++; $display("FAIL br_after_pc: got %h expected 10", pc); end
        checks++; if (instr_count !== 32'd2) begin errors++; $display("FAIL br_after_count: got %0d expected 2", instr_count); end
    endtask

    task automatic test_negative_branch();
        apply_reset();
        br_taken = 1'b1; br_pc = 64'h20; br_offset = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        br_taken = 1'b0;
        checks++; if (pc !== 64'h18) begin errors++; $display("FAIL neg_br_pc: got %h expected 18", pc); end
        // Offset bits shifted past bit 63 must be discarded: (4000..01 << 2) == 4.
        br_taken = 1'b1; br_pc = 64'h0; br_offset = 64'h4000_0000_0000_0001;
        step();
        br_taken = 1'b0;
        checks++; if (pc !== 64'h4) begin errors++; $display("FAIL shift_drop_pc: got %h expected 4", pc); end
    endtask

    task automatic test_pc_wrap();
        apply_reset();
        br_taken = 1'b1; br_pc = 64'h0; br_offset = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        br_taken = 1'b0;
        checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_target_pc: got %h expected fffffffffffffffc", pc); end
        step();
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", pc); end
        checks++; if (IFID_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_ifid_pc: got %h expected fffffffffffffffc", IFID_pc); end
        checks++; if (ID_instruction !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr: got %h expected fffffffc", ID_instruction); end
    endtask

    task automatic test_redirect_over_stall();
        apply_reset();
        stall = 1'b1; br_taken = 1'b1; br_pc = 64'h0; br_offset = 64'h1;
        step();
        br_taken = 1'b0;
        checks++; if (pc !== 64'h4) begin errors++; $display("FAIL brstall_pc: got %h expected 4", pc); end
        checks++; if (IFID_valid !== 1'b0) begin errors++; $display("FAIL brstall_valid: got %b expected 0", IFID_valid); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL brstall_count: got %0d expected 0", instr_count); end
        step();
        stall = 1'b0;
        checks++; if (pc !== 64'h4) begin errors++; $display("FAIL brstall_hold_pc: got %h expected 4", pc); end
        checks++; if (IFID_valid !== 1'b0) begin errors++; $display("FAIL brstall_hold_valid: got %b expected 0", IFID_valid); end
    endtask

    task automatic test_reset_during_stall();
        apply_reset();
        step(); step(); step();
        stall = 1'b1;
        step();
        checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL pre_rst_count: got %0d expected 3", instr_count); end
        reset = 1'b1; br_taken = 1'b1; br_pc = 64'h100; br_offset = 64'h1;
        step();
        reset = 1'b0; stall = 1'b0; br_taken = 1'b0;
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL rst_stall_pc: got %h expected 0", pc); end
        checks++; if (IFID_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_valid: got %b expected 0", IFID_valid); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL rst_stall_count: got %0d expected 0", instr_count); end
        checks++; if (ID_instruction !== 32'h0) begin errors++; $display("FAIL rst_stall_instr: got %h expected 0", ID_instruction); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_pc = '0; br_offset = '0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_negative_branch();
        test_pc_wrap();
        test_redirect_over_stall();
        test_reset_during_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
